seven_seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the four-digit common-anode 7-segment display.
- Consumes the 16-bit packed BCD word produced by the binary-to-BCD converter; digit 3 is bits [15:12], digit 0 is bits [3:0].
- Scans one digit at a time at a programmable refresh rate, with optional leading-zero blanking and per-digit decimal points.
- Drives the board anode and cathode pins directly.

---
 rtl/seven_seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with frame shadowing,
// leading-zero blanking and per-digit decimal points; all outputs registered.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_digit_sel;
  logic [15:0]      r_shadow_bcd;
  logic [3:0]       r_shadow_dp;
  logic             r_shadow_blank;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tick;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic             w_z3;
  logic             w_z2;
  logic             w_z1;
  logic [3:0]       w_an_next;
  logic [6:0]       w_seg_next;
  logic             w_dp_next;

  // Active-low {g..a} pattern; non-BCD nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_tick = en && (r_cnt == CNT_LAST);

  // Slot counter and digit select; both freeze while the display is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_digit_sel <= 2'd0;
    end else if (w_tick) begin
      r_cnt       <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;
    end else if (en) begin
      r_cnt       <= r_cnt + CNT_W'(1);
    end
  end

  // Frame shadow loads only at the 3->0 wrap so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_bcd   <= 16'h0000;
      r_shadow_dp    <= 4'b0000;
      r_shadow_blank <= 1'b0;
    end else if (w_tick && (r_digit_sel == 2'd3)) begin
      r_shadow_bcd   <= bcd_in;
      r_shadow_dp    <= dp_in;
      r_shadow_blank <= blank_en;
    end
  end

  assign w_z3 = (r_shadow_bcd[15:12] == 4'd0);
  assign w_z2 = w_z3 && (r_shadow_bcd[11:8] == 4'd0);
  assign w_z1 = w_z2 && (r_shadow_bcd[7:4] == 4'd0);

  // Next-cycle anode/cathode values derived from digit_sel and the shadow only.
  always_comb begin
    w_nibble   = 4'd0;
    w_blank    = 1'b0;
    w_an_next  = 4'b1111;
    w_seg_next = 7'b1111111;
    w_dp_next  = 1'b1;
    case (r_digit_sel)
      2'd3: begin
        w_nibble = r_shadow_bcd[15:12];
        w_blank  = r_shadow_blank && w_z3;
      end
      2'd2: begin
        w_nibble = r_shadow_bcd[11:8];
        w_blank  = r_shadow_blank && w_z2;
      end
      2'd1: begin
        w_nibble = r_shadow_bcd[7:4];
        w_blank  = r_shadow_blank && w_z1;
      end
      default: begin
        w_nibble = r_shadow_bcd[3:0];
        w_blank  = 1'b0;
      end
    endcase
    if (en) begin
      w_an_next  = ~(4'b0001 << r_digit_sel);
      w_seg_next = w_blank ? 7'b1111111 : seg_decode(w_nibble);
      w_dp_next  = ~r_shadow_dp[r_digit_sel];
    end else begin
      w_an_next  = 4'b1111;
      w_seg_next = 7'b1111111;
      w_dp_next  = 1'b1;
    end
  end

  // Output pin register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: an arithmetic display model checked
// every cycle, plus literal expectations for each scenario.
module tb_seven_seg_scan_driver;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  seven_seg_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_en(blank_en), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pattern(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: count enabled cycles; slot, frame and shadow follow by division.
  int          m_n;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_blank;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always @(posedge clk or posedge reset) begin
    int d;
    int upper;
    if (reset) begin
      m_n = 0; m_bcd = 16'h0000; m_dp = 4'b0000; m_blank = 1'b0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else if (en) begin
      d     = (m_n / DIV) % 4;
      upper = int'(m_bcd) >> (4 * d);
      e_an  = 4'(15 - (1 << d));
      e_seg = (m_blank && d != 0 && upper == 0) ? 7'b1111111 : digit_pattern(upper % 16);
      e_dp  = ~m_dp[d];
      m_n++;
      if (m_n % (4 * DIV) == 0) begin
        m_bcd = bcd_in; m_dp = dp_in; m_blank = blank_en;
      end
    end else begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking && !reset) begin
      n_checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                 $time, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_digit(input int d);
    bit found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (an === 4'(15 - (1 << d))) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_digit%0d got=timeout expected=an_active", d);
    end
  endtask

  task automatic expect_digit(input string name, input int d, input logic [6:0] s, input logic p);
    wait_digit(d);
    check(name, int'({an, seg, dp}), int'({4'(15 - (1 << d)), s, p}));
  endtask

  task automatic hold_len(output int len);
    logic [3:0] a;
    a = an;
    len = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an !== a) break;
      len++;
    end
  endtask

  localparam logic [6:0] BLK  = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  initial begin
    int len;
    clk = 1'b0; reset = 1'b0; en = 1'b0;
    bcd_in = 16'h0000; dp_in = 4'b0000; blank_en = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_vals", int'({an, seg, dp}), int'(12'b1111_1111111_1));

    // Scenario 1: first frame shows the reset shadow, then 1234.
    reset = 1'b0; en = 1'b1; bcd_in = 16'h1234; checking = 1'b1;
    @(negedge clk);
    expect_digit("f0_d0", 0, 7'b1000000, 1'b1);
    expect_digit("f0_d1", 1, 7'b1000000, 1'b1);
    expect_digit("f0_d2", 2, 7'b1000000, 1'b1);
    expect_digit("f0_d3", 3, 7'b1000000, 1'b1);
    expect_digit("s1_d0", 0, 7'b0011001, 1'b1);
    expect_digit("s1_d1", 1, 7'b0110000, 1'b1);
    hold_len(len);
    check("s1_hold", len, 4);
    expect_digit("s1_d2", 2, 7'b0100100, 1'b1);
    expect_digit("s1_d3", 3, 7'b1111001, 1'b1);

    // Scenario 2: leading-zero blanking.
    bcd_in = 16'h0007; blank_en = 1'b1;
    wait_digit(1);
    expect_digit("s2_d0", 0, 7'b1111000, 1'b1);
    expect_digit("s2_d1", 1, BLK, 1'b1);
    expect_digit("s2_d2", 2, BLK, 1'b1);
    expect_digit("s2_d3", 3, BLK, 1'b1);
    bcd_in = 16'h0000;
    wait_digit(1);
    expect_digit("s2z_d0", 0, 7'b1000000, 1'b1);
    expect_digit("s2z_d1", 1, BLK, 1'b1);
    expect_digit("s2z_d2", 2, BLK, 1'b1);
    expect_digit("s2z_d3", 3, BLK, 1'b1);

    // Scenario 3: mid-frame input change must not tear.
    bcd_in = 16'h1111; blank_en = 1'b0;
    wait_digit(1);
    expect_digit("s3_d0", 0, 7'b1111001, 1'b1);
    expect_digit("s3_d1", 1, 7'b1111001, 1'b1);
    bcd_in = 16'h2222;
    expect_digit("s3_d2", 2, 7'b1111001, 1'b1);
    expect_digit("s3_d3", 3, 7'b1111001, 1'b1);
    expect_digit("s3n_d0", 0, 7'b0100100, 1'b1);
    expect_digit("s3n_d1", 1, 7'b0100100, 1'b1);

    // Scenario 4: illegal nibble counts as nonzero for blanking.
    bcd_in = 16'h0A05; blank_en = 1'b1;
    wait_digit(1);
    expect_digit("s4_d0", 0, 7'b0010010, 1'b1);
    expect_digit("s4_d1", 1, 7'b1000000, 1'b1);
    expect_digit("s4_d2", 2, DASH, 1'b1);
    expect_digit("s4_d3", 3, BLK, 1'b1);

    // Scenario 5: decimal point on digit 2 only.
    dp_in = 4'b0100;
    wait_digit(1);
    expect_digit("s5_d0", 0, 7'b0010010, 1'b1);
    expect_digit("s5_d1", 1, 7'b1000000, 1'b1);
    expect_digit("s5_d2", 2, DASH, 1'b0);
    expect_digit("s5_d3", 3, BLK, 1'b1);

    // Scenario 6: disable mid-slot, then resume the same digit.
    wait_digit(2);
    en = 1'b0;
    @(negedge clk);
    check("s6_off", int'({an, seg, dp}), int'(12'b1111_1111111_1));
    repeat (9) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("s6_resume_an", int'(an), int'(4'b1011));
    hold_len(len);
    check("s6_remaining", len, 3);

    // Async reset between edges, then a full first slot on digit 0.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", int'({an, seg, dp}), int'(12'b1111_1111111_1));
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    wait_digit(0);
    check("rst_d0", int'({an, seg, dp}), int'({4'b1110, 7'b1000000, 1'b1}));
    hold_len(len);
    check("rst_slot", len, 4);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
